pin_frame_sequencer: RTL and testbench



---
 rtl/phys_pkg.sv | 29 ++
 rtl/coll_timeout_counter.sv | 28 ++
 rtl/pin_frame_sequencer.sv | 158 +++++++++++++++
 tb/tb_pin_frame_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_pkg.sv
// Shared physics-pipeline definitions: lane geometry, pin count, the
// frame sequencer state encoding and a saturating counter helper.
package phys_pkg;

   localparam int unsigned NUM_PINS  = 10;
   localparam int unsigned PIN_IDX_W = 4;

   localparam logic [15:0] LANE_LENGTH = 16'd1800;
   localparam logic [15:0] COLLIDE_Y   = 16'd800;

   localparam logic [PIN_IDX_W-1:0] LAST_PIN = PIN_IDX_W'(NUM_PINS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_BALL_STEP,
      S_BALL_CHECK,
      S_COLL_REQ,
      S_COLL_WAIT,
      S_PIN_UPDATE,
      S_SETTLE_WAIT,
      S_DONE
   } seq_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/coll_timeout_counter.sv
// Cycle counter for bounded handshake waits: cleared while idle, counts while
// enabled and flags the cycle on which LIMIT enabled cycles have elapsed.
module coll_timeout_counter #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW   = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
   localparam int unsigned LAST = (LIMIT > 0) ? LIMIT - 1 : 0;

   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         count_q <= '0;
      end else if (en_i && !expired_o) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign expired_o = en_i && (count_q == CW'(LAST));

endmodule

// File: rtl/pin_frame_sequencer.sv
// Per-frame scheduler for the bowling physics pipeline: steps the ball, scans
// every pin through the shared collision unit, strobes pin dynamics, then settles.
module pin_frame_sequencer
   import phys_pkg::*;
#(
   parameter int unsigned SETTLE_FRAMES = 30,
   parameter int unsigned COLL_TIMEOUT  = 15
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        throw_start_in,
   input  logic        frame_tick_in,
   input  logic [15:0] ball_y_in,
   output logic        ball_step_out,
   output logic        coll_req_out,
   output logic [3:0]  coll_pin_idx_out,
   input  logic        coll_ready_in,
   input  logic        coll_valid_in,
   input  logic        coll_hit_in,
   output logic        pins_update_out,
   output logic [9:0]  pins_hit_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        overrun_out,
   output logic [15:0] frame_count_out
);

   localparam int unsigned SETTLE_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

   seq_state_e           state_q;
   logic [PIN_IDX_W-1:0] idx_q;
   logic [SETTLE_W-1:0]  settle_q;
   logic [NUM_PINS-1:0]  hit_q;
   logic [15:0]          frame_cnt_q;
   logic                 ball_step_q;
   logic                 coll_req_q;
   logic                 pins_update_q;
   logic                 done_q;
   logic                 overrun_q;
   logic                 in_wait;
   logic                 tick_dropped;
   logic                 tmo_expired;

   assign in_wait      = (state_q == S_COLL_WAIT);
   assign tick_dropped = frame_tick_in && (state_q inside {S_BALL_STEP, S_BALL_CHECK,
                                           S_COLL_REQ, S_COLL_WAIT, S_PIN_UPDATE});

   coll_timeout_counter #(.LIMIT(COLL_TIMEOUT)) u_coll_timeout (
      .clk_i     (clk_in),
      .rst_i     (rst_in),
      .clear_i   (!in_wait),
      .en_i      (in_wait),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         settle_q      <= '0;
         hit_q         <= '0;
         frame_cnt_q   <= '0;
         ball_step_q   <= 1'b0;
         coll_req_q    <= 1'b0;
         pins_update_q <= 1'b0;
         done_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         ball_step_q   <= 1'b0;
         pins_update_q <= 1'b0;
         done_q        <= 1'b0;
         if (tick_dropped) overrun_q <= 1'b1;

         unique case (state_q)
            S_IDLE: begin
               if (throw_start_in) begin
                  state_q     <= S_WAIT_TICK;
                  hit_q       <= '0;
                  frame_cnt_q <= '0;
                  overrun_q   <= 1'b0;
               end
            end
            S_WAIT_TICK: begin
               if (frame_tick_in) begin
                  state_q     <= S_BALL_STEP;
                  ball_step_q <= 1'b1;
                  frame_cnt_q <= sat_inc16(frame_cnt_q);
               end
            end
            S_BALL_STEP: state_q <= S_BALL_CHECK;
            S_BALL_CHECK: begin
               if (ball_y_in >= LANE_LENGTH) begin
                  settle_q <= SETTLE_W'(SETTLE_FRAMES);
                  if (SETTLE_FRAMES == 0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_SETTLE_WAIT;
                  end
               end else if (ball_y_in >= COLLIDE_Y) begin
                  state_q    <= S_COLL_REQ;
                  idx_q      <= '0;
                  coll_req_q <= 1'b1;
               end else begin
                  state_q       <= S_PIN_UPDATE;
                  pins_update_q <= 1'b1;
               end
            end
            S_COLL_REQ: begin
               if (coll_ready_in) begin
                  state_q    <= S_COLL_WAIT;
                  coll_req_q <= 1'b0;
               end
            end
            S_COLL_WAIT: begin
               // valid wins over a simultaneous timeout, so a last-cycle result still counts
               if (coll_valid_in || tmo_expired) begin
                  if (coll_valid_in && coll_hit_in) hit_q[idx_q] <= 1'b1;
                  if (idx_q == LAST_PIN) begin
                     idx_q         <= '0;
                     state_q       <= S_PIN_UPDATE;
                     pins_update_q <= 1'b1;
                  end else begin
                     idx_q      <= idx_q + PIN_IDX_W'(1);
                     state_q    <= S_COLL_REQ;
                     coll_req_q <= 1'b1;
                  end
               end
            end
            S_PIN_UPDATE: state_q <= S_WAIT_TICK;
            S_SETTLE_WAIT: begin
               // a tick landing on the strobe cycle is not taken, keeping each strobe one cycle wide
               if (pins_update_q && (settle_q == '0)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (frame_tick_in && !pins_update_q) begin
                  pins_update_q <= 1'b1;
                  settle_q      <= settle_q - SETTLE_W'(1);
                  frame_cnt_q   <= sat_inc16(frame_cnt_q);
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ball_step_out    = ball_step_q;
   assign coll_req_out     = coll_req_q;
   assign coll_pin_idx_out = idx_q;
   assign pins_update_out  = pins_update_q;
   assign pins_hit_out     = hit_q;
   assign busy_out         = (state_q != S_IDLE);
   assign done_out         = done_q;
   assign overrun_out      = overrun_q;
   assign frame_count_out  = frame_cnt_q;

endmodule

// File: tb/tb_pin_frame_sequencer.sv
// Randomised self-checking bench for pin_frame_sequencer with a behavioural
// collision-unit responder and a frame-level latency / hit-mask model.
module tb_pin_frame_sequencer;

   localparam int SETTLE_N = 3;
   localparam int TIMEOUT  = 15;

   logic        clk_in;
   logic        rst_in;
   logic        throw_start_in;
   logic        frame_tick_in;
   logic [15:0] ball_y_in;
   logic        ball_step_out;
   logic        coll_req_out;
   logic [3:0]  coll_pin_idx_out;
   logic        coll_ready_in;
   logic        coll_valid_in;
   logic        coll_hit_in;
   logic        pins_update_out;
   logic [9:0]  pins_hit_out;
   logic        busy_out;
   logic        done_out;
   logic        overrun_out;
   logic [15:0] frame_count_out;

   pin_frame_sequencer #(.SETTLE_FRAMES(SETTLE_N), .COLL_TIMEOUT(TIMEOUT)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .throw_start_in   (throw_start_in),
      .frame_tick_in    (frame_tick_in),
      .ball_y_in        (ball_y_in),
      .ball_step_out    (ball_step_out),
      .coll_req_out     (coll_req_out),
      .coll_pin_idx_out (coll_pin_idx_out),
      .coll_ready_in    (coll_ready_in),
      .coll_valid_in    (coll_valid_in),
      .coll_hit_in      (coll_hit_in),
      .pins_update_out  (pins_update_out),
      .pins_hit_out     (pins_hit_out),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .overrun_out      (overrun_out),
      .frame_count_out  (frame_count_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model of the architecturally visible throw state
   logic [9:0] m_mask;
   int         m_fc;
   logic       m_ovr;

   // collision unit behaviour per pin: ready stall, result delay (0 = never), hit
   int rdy_wait[10];
   int resp_dly[10];
   bit hit_pat[10];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_ctl"}, {26'd0, ball_step_out, coll_req_out, pins_update_out,
                               busy_out, done_out, overrun_out}, 32'd0);
      check_eq({tag, "_idx"}, {28'd0, coll_pin_idx_out}, 32'd0);
      check_eq({tag, "_hit"}, {22'd0, pins_hit_out}, 32'd0);
      check_eq({tag, "_fc"},  {16'd0, frame_count_out}, 32'd0);
   endtask

   task automatic cfg_default();
      for (int p = 0; p < 10; p++) begin
         rdy_wait[p] = 0;
         resp_dly[p] = 1;
         hit_pat[p]  = 1'b0;
      end
   endtask

   task automatic cfg_random();
      int r;
      for (int p = 0; p < 10; p++) begin
         rdy_wait[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         r = $urandom_range(0, 9);
         resp_dly[p] = (r == 0) ? 0 : ((r == 1) ? TIMEOUT : int'($urandom_range(1, 3)));
         hit_pat[p]  = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic start_throw();
      throw_start_in = 1'b1;
      @(negedge clk_in);
      throw_start_in = 1'b0;
      m_mask = '0;
      m_fc   = 0;
      m_ovr  = 1'b0;
      check_eq("start_busy", {31'd0, busy_out}, 32'd1);
      check_eq("start_mask", {22'd0, pins_hit_out}, 32'd0);
      check_eq("start_fc", {16'd0, frame_count_out}, 32'd0);
      check_eq("start_ovr", {31'd0, overrun_out}, 32'd0);
   endtask

   // One in-lane frame; starts on a negedge with the DUT waiting for a tick.
   // inj_mode: -1 no extra tick, 0 random extra tick, >0 extra tick on that cycle.
   task automatic do_frame(input logic [15:0] y, input int inj_mode);
      bit collide;
      int exp_lat, inj, w;
      int step_cnt, step_at, upd_at, xfers, exp_pin, req_idx;
      int low_left, resp_left, resp_pin, stable_bad;
      bit in_req;
      collide = (y >= 16'd800);
      exp_lat = 3;
      if (collide) begin
         for (int p = 0; p < 10; p++) begin
            w = (resp_dly[p] >= 1 && resp_dly[p] <= TIMEOUT) ? resp_dly[p] : TIMEOUT;
            exp_lat += rdy_wait[p] + 1 + w;
            if (hit_pat[p] && resp_dly[p] >= 1 && resp_dly[p] <= TIMEOUT) m_mask[p] = 1'b1;
         end
      end
      inj = (inj_mode == 0) ? int'($urandom_range(1, exp_lat - 1)) : inj_mode;
      if (inj > 0) m_ovr = 1'b1;
      m_fc++;

      ball_y_in = y;
      frame_tick_in = 1'b1;
      step_cnt = 0; step_at = -1; upd_at = -1; xfers = 0; exp_pin = 0; req_idx = 0;
      low_left = 0; resp_left = -1; resp_pin = 0; stable_bad = 0; in_req = 1'b0;
      for (int c = 1; c <= 600 && upd_at < 0; c++) begin
         @(negedge clk_in);
         frame_tick_in  = (c == inj);
         throw_start_in = (c == 2);
         coll_valid_in  = 1'b0;
         coll_hit_in    = 1'($urandom_range(0, 1));
         if (ball_step_out) begin step_cnt++; step_at = c; end
         if (pins_update_out) upd_at = c;
         if (resp_left > 0) begin
            resp_left--;
            if (resp_left == 0) begin
               coll_valid_in = 1'b1;
               coll_hit_in   = hit_pat[resp_pin];
               resp_left     = -1;
            end
         end
         if (coll_req_out) begin
            if (!in_req) begin
               in_req = 1'b1;
               check_eq("req_idx", {28'd0, coll_pin_idx_out}, exp_pin);
               req_idx  = coll_pin_idx_out;
               low_left = (exp_pin < 10) ? rdy_wait[exp_pin] : 0;
            end else if (coll_pin_idx_out != 4'(req_idx)) begin
               stable_bad++;
            end
            if (low_left > 0) begin
               coll_ready_in = 1'b0;
               low_left--;
            end else begin
               coll_ready_in = 1'b1;
               in_req   = 1'b0;
               xfers++;
               resp_pin  = (exp_pin < 10) ? exp_pin : 0;
               resp_left = (resp_dly[resp_pin] == 0) ? -1 : resp_dly[resp_pin];
               exp_pin++;
            end
         end else begin
            if (in_req) stable_bad++;
            in_req = 1'b0;
            coll_ready_in = 1'($urandom_range(0, 1));
         end
      end
      frame_tick_in  = 1'b0;
      throw_start_in = 1'b0;
      coll_ready_in  = 1'b0;
      coll_valid_in  = 1'b0;
      check_eq("frame_step_cnt", step_cnt, 1);
      check_eq("frame_step_at", step_at, 1);
      check_eq("frame_upd_latency", upd_at, exp_lat);
      check_eq("frame_xfers", xfers, collide ? 10 : 0);
      check_eq("req_stable", stable_bad, 0);
      check_eq("frame_mask", {22'd0, pins_hit_out}, {22'd0, m_mask});
      check_eq("frame_fc", {16'd0, frame_count_out}, m_fc);
      check_eq("frame_ovr", {31'd0, overrun_out}, {31'd0, m_ovr});
      @(negedge clk_in);
      check_eq("upd_single", {30'd0, pins_update_out, busy_out}, 32'd1);
   endtask

   // Ball leaves the lane: settle ticks each give one strobe, then done.
   task automatic do_exit(input logic [15:0] y);
      int bad_step, bad_upd;
      bad_step = 0;
      bad_upd  = 0;
      ball_y_in = y;
      frame_tick_in = 1'b1;
      m_fc++;
      @(negedge clk_in);
      frame_tick_in = 1'b0;
      check_eq("exit_step", {31'd0, ball_step_out}, 32'd1);
      @(negedge clk_in);
      ball_y_in = 16'($urandom_range(0, 65535));
      for (int k = 0; k < SETTLE_N; k++) begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk_in);
            if (ball_step_out) bad_step++;
            if (pins_update_out || done_out) bad_upd++;
         end
         frame_tick_in = 1'b1;
         m_fc++;
         @(negedge clk_in);
         frame_tick_in = 1'b0;
         check_eq("settle_upd", {31'd0, pins_update_out}, 32'd1);
         if (ball_step_out || done_out) bad_step++;
      end
      @(negedge clk_in);
      check_eq("done_pulse", {29'd0, done_out, pins_update_out, busy_out}, 32'b101);
      @(negedge clk_in);
      check_eq("after_done", {30'd0, done_out, busy_out}, 32'd0);
      check_eq("settle_no_step", bad_step, 0);
      check_eq("settle_no_extra", bad_upd, 0);
      check_eq("exit_fc", {16'd0, frame_count_out}, m_fc);
      check_eq("exit_mask", {22'd0, pins_hit_out}, {22'd0, m_mask});
      frame_tick_in = 1'b1;
      @(negedge clk_in);
      frame_tick_in = 1'b0;
      @(negedge clk_in);
      check_eq("idle_tick", {15'd0, busy_out, frame_count_out}, m_fc);
      check_eq("idle_hold", {21'd0, overrun_out, pins_hit_out}, {21'd0, m_ovr, m_mask});
   endtask

   function automatic logic [15:0] rand_lane_y();
      int z;
      z = $urandom_range(0, 9);
      case (z)
         0:       return 16'd799;
         1:       return 16'd800;
         2:       return 16'd1799;
         3, 4:    return 16'($urandom_range(0, 799));
         default: return 16'($urandom_range(800, 1799));
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b1;
      throw_start_in = 1'b0;
      frame_tick_in  = 1'b0;
      ball_y_in      = '0;
      coll_ready_in  = 1'b0;
      coll_valid_in  = 1'b0;
      coll_hit_in    = 1'b0;
      m_mask = '0;
      m_fc   = 0;
      m_ovr  = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      check_outputs_zero("reset");

      // directed throw: low frame, clean scan, stalls / timeout / overrun, exit
      start_throw();
      cfg_default();
      do_frame(16'd100, -1);
      hit_pat[0] = 1'b1;
      hit_pat[4] = 1'b1;
      do_frame(16'd900, -1);
      check_eq("mask_pins_0_4", {22'd0, pins_hit_out}, 32'b0000010001);
      cfg_default();
      rdy_wait[3] = 5;
      resp_dly[7] = 0;
      hit_pat[7]  = 1'b1;
      resp_dly[2] = TIMEOUT;
      hit_pat[2]  = 1'b1;
      do_frame(16'd900, 4);
      check_eq("timeout_bit7", {31'd0, pins_hit_out[7]}, 32'd0);
      check_eq("overrun_sticky", {31'd0, overrun_out}, 32'd1);
      do_exit(16'd1800);

      // reset while a request is outstanding
      start_throw();
      cfg_random();
      do_frame(16'd1200, 0);
      ball_y_in = 16'd1000;
      frame_tick_in = 1'b1;
      @(negedge clk_in);
      frame_tick_in = 1'b0;
      coll_ready_in = 1'b0;
      repeat (4) @(negedge clk_in);
      check_eq("req_before_rst", {30'd0, coll_req_out, busy_out}, 32'b11);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check_outputs_zero("mid_rst");
      m_mask = '0;
      m_fc   = 0;
      m_ovr  = 1'b0;
      @(negedge clk_in);
      check_eq("rst_stays_idle", {31'd0, busy_out}, 32'd0);
      start_throw();
      cfg_default();
      hit_pat[9] = 1'b1;
      do_frame(16'd800, -1);
      do_exit(16'hFFFF);

      // randomised throws
      for (int t = 0; t < 4; t++) begin
         start_throw();
         repeat ($urandom_range(3, 5)) begin
            cfg_random();
            do_frame(rand_lane_y(), ($urandom_range(0, 3) == 0) ? 0 : -1);
         end
         do_exit(($urandom_range(0, 1) == 0) ? 16'd1800 : 16'($urandom_range(1800, 65535)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
